vga_fb_scheduler: RTL and testbench

Schedules the single-port pixel frame-buffer RAM between the VGA display fetch and a pixel-writer port, and manages double-buffer page flipping. It sits between the VGA timing controller, which supplies px_h/px_v and consumes px_data, and a synchronous single-port RAM. Display reads always win the port during the active area. Buffered writes drain only in cycles that do not need a display read.

---
 rtl/vga_fb_scheduler.sv | 157 +++++++++++++++
 tb/tb_vga_fb_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_scheduler.sv
// Shares one frame-buffer RAM port: display reads win in the active area, queued pixel writes drain otherwise.
// Display latency 3 cycles (coords -> px_data); writer is stalled when the FIFO is full or a page flip is pending.
module vga_fb_scheduler #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int H_BITS     = 10,
    parameter int V_BITS     = 9,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     px_clk,
    input  logic                     rst,
    input  logic [10:0]              px_h,
    input  logic [10:0]              px_v,
    output logic [DATA_W-1:0]        px_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [H_BITS+V_BITS-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     swap_req,
    output logic                     swap_done,
    output logic                     front_page,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [V_BITS+H_BITS:0]   mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);
    localparam int A_W   = H_BITS + V_BITS;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [10:0]    L_H_ACT = 11'(H_ACTIVE);
    localparam logic [10:0]    L_V_ACT = 11'(V_ACTIVE);
    localparam logic [PTR_W:0] L_FULL  = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_PEND = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_flip;

    logic [A_W-1:0]    r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W:0]    r_count;

    logic w_active;
    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    logic                   r_front;
    logic                   r_swap_done;
    logic                   r_mem_en;
    logic                   r_mem_we;
    logic [V_BITS+H_BITS:0] r_mem_addr;
    logic [DATA_W-1:0]      r_mem_wdata;
    logic                   r_act1;
    logic                   r_act2;
    logic [DATA_W-1:0]      r_px_data;

    assign w_active = (px_h < L_H_ACT) && (px_v < L_V_ACT);
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == L_FULL);
    assign wr_ready = !w_full && (r_state == S_RUN);
    assign w_push   = wr_valid && wr_ready;
    // Pop looks only at entries already stored, so a same-cycle push never bypasses to the RAM.
    assign w_pop    = !w_active && !w_empty;

    always_ff @(posedge px_clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= wr_addr;
            r_fifo_data[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_flip      = 1'b0;
        case (r_state)
            S_RUN: begin
                if (swap_req) w_state_nxt = S_PEND;
            end
            S_PEND: begin
                // Flip only once every queued write has landed in the old back page.
                if (w_empty && (px_v >= L_V_ACT)) begin
                    w_flip      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_front     <= 1'b0;
            r_swap_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_front     <= r_front ^ w_flip;
            r_swap_done <= w_flip;
        end
    end

    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_act1      <= 1'b0;
            r_act2      <= 1'b0;
            r_px_data   <= '0;
        end else begin
            r_mem_en <= w_active || w_pop;
            r_mem_we <= w_pop;
            if (w_active) begin
                r_mem_addr <= {r_front, px_v[V_BITS-1:0], px_h[H_BITS-1:0]};
            end else if (w_pop) begin
                r_mem_addr  <= {~r_front, r_fifo_addr[r_rptr]};
                r_mem_wdata <= r_fifo_data[r_rptr];
            end
            r_act1    <= w_active;
            r_act2    <= r_act1;
            r_px_data <= r_act2 ? mem_rdata : '0;
        end
    end

    assign px_data    = r_px_data;
    assign swap_done  = r_swap_done;
    assign front_page = r_front;
    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Directed bench: queue-based frame-buffer model checked every cycle, plus literal spot checks.
module tb_vga_fb_scheduler;
    logic        px_clk;
    logic        rst;
    logic [10:0] px_h;
    logic [10:0] px_v;
    logic [11:0] px_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [18:0] wr_addr;
    logic [11:0] wr_data;
    logic        swap_req;
    logic        swap_done;
    logic        front_page;
    logic        mem_en;
    logic        mem_we;
    logic [19:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    vga_fb_scheduler dut (
        .px_clk    (px_clk),
        .rst       (rst),
        .px_h      (px_h),
        .px_v      (px_v),
        .px_data   (px_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .swap_req  (swap_req),
        .swap_done (swap_done),
        .front_page(front_page),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial begin
        px_clk = 1'b0;
        forever #5 px_clk = ~px_clk;
    end

    function automatic logic [11:0] pat(input logic [19:0] a);
        logic [31:0] t;
        t = {12'b0, a} * 32'd7 + 32'd3;
        return t[11:0];
    endfunction

    // RAM attached to the DUT; returns 0xFFF whenever no read was issued.
    logic [11:0] bram  [0:1048575];
    bit          bflag [0:1048575];
    always @(posedge px_clk) begin
        if (mem_en && mem_we) begin
            bram[mem_addr]  <= mem_wdata;
            bflag[mem_addr] <= 1'b1;
        end
        if (mem_en && !mem_we)
            mem_rdata <= bflag[mem_addr] ? bram[mem_addr] : pat(mem_addr);
        else
            mem_rdata <= 12'hFFF;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [18:0] a;
        logic [11:0] d;
    } ent_t;

    ent_t        mq[$];
    bit          m_pend;
    logic        m_front;
    logic        e_en, e_we, e_sd;
    logic [19:0] e_addr;
    logic [11:0] e_wd;
    logic [11:0] p_cur, p1, p2;
    logic [11:0] mram  [0:1048575];
    bit          mflag [0:1048575];

    function automatic logic [11:0] mrd(input logic [19:0] a);
        return mflag[a] ? mram[a] : pat(a);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pend  = 1'b0;
        m_front = 1'b0;
        e_en = 1'b0; e_we = 1'b0; e_sd = 1'b0;
        e_addr = '0; e_wd = '0;
        p_cur = '0; p1 = '0; p2 = '0;
    endtask

    task automatic model_step();
        bit   act, empty0, rdy;
        ent_t e;
        act    = (px_h < 11'd640) && (px_v < 11'd480);
        empty0 = (mq.size() == 0);
        rdy    = (mq.size() < 4) && !m_pend;
        e_en = 1'b0; e_we = 1'b0; e_sd = 1'b0;
        if (act) begin
            e_en   = 1'b1;
            e_addr = {m_front, px_v[8:0], px_h[9:0]};
        end else if (!empty0) begin
            e      = mq.pop_front();
            e_en   = 1'b1;
            e_we   = 1'b1;
            e_addr = {~m_front, e.a};
            e_wd   = e.d;
        end
        p_cur = p1;
        p1    = p2;
        p2    = act ? mrd(e_addr) : 12'h000;
        if (wr_valid && rdy) begin
            e = {wr_addr, wr_data};
            mq.push_back(e);
        end
        if (m_pend && empty0 && (px_v >= 11'd480)) begin
            m_pend  = 1'b0;
            m_front = ~m_front;
            e_sd    = 1'b1;
        end else if (!m_pend && swap_req) begin
            m_pend = 1'b1;
        end
    endtask

    initial begin
        forever begin
            @(negedge px_clk);
            if (rst)
                model_reset();
            else if (e_en && e_we) begin
                mram[e_addr]  = e_wd;
                mflag[e_addr] = 1'b1;
            end
            chk("m_mem_en",     mem_en,     e_en);
            chk("m_mem_we",     mem_we,     e_we);
            chk("m_mem_addr",   mem_addr,   e_addr);
            chk("m_mem_wdata",  mem_wdata,  e_wd);
            chk("m_px_data",    px_data,    p_cur);
            chk("m_swap_done",  swap_done,  e_sd);
            chk("m_front_page", front_page, m_front);
            chk("m_wr_ready",   wr_ready,   (mq.size() < 4) && !m_pend);
            if (!rst) model_step();
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge px_clk);
        #1;
    endtask

    task automatic at(input int h, input int v);
        px_h = 11'(h);
        px_v = 11'(v);
    endtask

    task automatic push(input logic [18:0] a, input logic [11:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0;
        at(700, 500);
        step(); step();
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_px_data", px_data, 0);
        chk("rst_front", front_page, 0);
        chk("rst_wr_ready", wr_ready, 1);
        rst = 1'b0;

        // three active pixels on line 0
        at(0, 0); step();
        chk("rd0_addr", mem_addr, 20'h00000);
        chk("rd0_en", mem_en, 1);
        at(1, 0); step();
        chk("rd1_addr", mem_addr, 20'h00001);
        at(2, 0); step();
        chk("rd2_addr", mem_addr, 20'h00002);
        chk("px0", px_data, 12'h003);
        at(700, 0); step();
        chk("px1", px_data, 12'h00A);
        step();
        chk("px2", px_data, 12'h011);

        // blanking: RAM bus shows 0xFFF but pixels must be black
        at(700, 10);
        step(); step(); step();
        chk("blank_px", px_data, 0);
        chk("blank_we", mem_we, 0);

        // four pushes during active area fill the FIFO
        for (int i = 0; i < 4; i++) begin
            at(i, 1);
            push(19'h0140A + 19'(i), 12'hA01 + 12'(i));
            step();
        end
        wr_valid = 1'b0;
        chk("full_ready", wr_ready, 0);
        for (int i = 4; i < 10; i++) begin
            at(i, 1); step();
            chk("act_no_we", mem_we, 0);
        end
        for (int i = 0; i < 4; i++) begin
            at(640 + i, 1); step();
            chk("drain_we", mem_we, 1);
            chk("drain_addr", mem_addr, 20'h8140A + 20'(i));
            chk("drain_data", mem_wdata, 12'hA01 + 12'(i));
        end
        at(700, 1); step();
        chk("drained_we", mem_we, 0);
        chk("drained_ready", wr_ready, 1);

        // push and pop in the same cycle at level 2
        at(0, 2); push(19'h00100, 12'hB01); step();
        at(1, 2); push(19'h00101, 12'hB02); step();
        at(700, 2); push(19'h00102, 12'hB03); step();
        wr_valid = 1'b0;
        chk("pp0_addr", mem_addr, 20'h80100);
        chk("pp0_data", mem_wdata, 12'hB01);
        step();
        chk("pp1_data", mem_wdata, 12'hB02);
        step();
        chk("pp2_addr", mem_addr, 20'h80102);
        chk("pp2_data", mem_wdata, 12'hB03);
        step();
        chk("pp_done_we", mem_we, 0);

        // page flip with two entries queued
        at(0, 100); push(19'h12345, 12'hC01); step();
        at(1, 100); push(19'h12346, 12'hC02); step();
        wr_valid = 1'b0;
        at(2, 100); swap_req = 1'b1; step();
        swap_req = 1'b0;
        chk("pend_ready", wr_ready, 0);
        at(3, 100); push(19'h00777, 12'hDDD); step();
        wr_valid = 1'b0;
        at(700, 100); step();
        chk("sw_w0_addr", mem_addr, 20'h92345);
        chk("sw_w0_data", mem_wdata, 12'hC01);
        step();
        chk("sw_w1_addr", mem_addr, 20'h92346);
        step();
        chk("sw_early_done", swap_done, 0);
        step();
        chk("sw_early_front", front_page, 0);
        at(0, 480); step();
        chk("sw_done", swap_done, 1);
        chk("sw_front", front_page, 1);
        chk("sw_ready", wr_ready, 1);
        at(1, 480); step();
        chk("sw_done_pulse", swap_done, 0);
        at(0, 0); step();
        chk("new_front_addr", mem_addr, 20'h80000);
        chk("new_front_we", mem_we, 0);

        // reset while in PEND with three entries queued
        at(10, 0); push(19'h00AAA, 12'hE01); step();
        at(11, 0); push(19'h00AAB, 12'hE02); step();
        at(12, 0); push(19'h00AAC, 12'hE03); swap_req = 1'b1; step();
        wr_valid = 1'b0; swap_req = 1'b0;
        chk("pre_rst_ready", wr_ready, 0);
        at(13, 0); step();
        at(14, 0); rst = 1'b1; #1;
        chk("mid_rst_en", mem_en, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_front", front_page, 0);
        chk("mid_rst_ready", wr_ready, 1);
        step();
        rst = 1'b0;
        at(700, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("post_rst_no_we", mem_we, 0);
        end
        chk("post_rst_front", front_page, 0);
        chk("post_rst_ready", wr_ready, 1);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
